alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Parametrised execute stage that replaces the combinational ALU-control/ALU pair with one registered unit. It decodes {ALUop, funct3, funct7}, performs single-cycle integer ops and branch compares, and runs RV32M-style multiply/divide iteratively. The unit sits between ID/EX operand registers and the EX/MEM latch. It uses a valid/ready handshake so the core stalls only while a multi-cycle op is in flight.

Parameters:
XLEN, 32, datapath width in bits; legal values are powers of two, 8 or more.
MD_EN, 1, enables mul/div decode; when 0, M-ops decode as illegal.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands and op are valid this cycle
in_ready  out  1  unit can accept; high only in IDLE
ALUop  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
op_a  in  XLEN  rs1 value
op_b  in  XLEN  rs2 value or immediate
out_valid  out  1  one-cycle pulse; result, branch_taken and illegal are valid
result  out  XLEN  registered result
branch_taken  out  1  branch condition true (ALUop=01 only)
illegal  out  1  unsupported op combination

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: state=IDLE; out_valid, branch_taken, illegal = 0; result = 0; iteration counter = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-operation: the in-flight op is abandoned with no out_valid; the unit returns to IDLE next cycle.
- Accept: an op is accepted when in_valid && in_ready. The unit registers operands and decoded op on that edge.
- Single-cycle ops: out_valid goes high on the edge after accept (latency 1). State stays IDLE, so back-to-back accepts run every cycle.
- Decode, ALUop=00: ADD.
- Decode, ALUop=01 (branch): result = op_a - op_b.
  - funct3 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu.
  - 010 and 011 are illegal.
- Decode, ALUop=10 (R-type):
  - funct7=0000000: add, sll, slt, sltu, xor, srl, or, and by funct3 000..111.
  - funct7=0100000: sub (000), sra (101).
  - funct7=0000001 with MD_EN=1: mul (000, low XLEN bits), div (100), divu (101), rem (110), remu (111).
  - Other funct3 values with funct7=0000001 are illegal.
- Decode, ALUop=11 (I-type): addi, slti, sltiu, xori, ori, andi ignore funct7. slli and srli need funct7=0000000; srai needs funct7=0100000.
- Shifts: amount is op_b[log2(XLEN)-1:0]. slt/sltu return 1 or 0, zero-extended.
- Illegal: result=0, illegal=1, latency 1. Any other combination is illegal.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on accepting mul. IDLE -> DIV on accepting div/divu/rem/remu.
  - MUL/DIV -> IDLE when the counter reaches XLEN-1; out_valid is asserted on that transition edge.
  - in_ready = 0 in MUL and DIV. in_valid is ignored while busy.
- MUL: shift-add, one bit per cycle, for XLEN iterations. out_valid arrives exactly XLEN cycles after the accept edge.
- DIV: restoring division on magnitudes, one bit per cycle, for XLEN iterations; same latency as MUL.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Div boundaries (same XLEN-cycle latency):
  - Divide by zero: quotient = all ones, remainder = op_a.
  - Signed overflow (op_a = -2^(XLEN-1), op_b = -1): quotient = op_a, remainder = 0.
- All arithmetic wraps modulo 2^XLEN. No exception outputs besides illegal.
- Outputs hold their values between pulses, except out_valid.

Test Plan:
- After reset release: in_ready=1, out_valid=0, result=0. Then add 5+7 -> one cycle later out_valid=1, result=12, illegal=0.
- Branch ALUop=01, funct3=100, op_a=0xFFFFFFFF, op_b=1 -> branch_taken=1. Same operands with funct3=110 -> branch_taken=0.
- mul 0xFFFFFFFF*3 -> in_ready=0 for 32 cycles, then out_valid at cycle 32 with result=0xFFFFFFFD. in_valid pulses during the busy window are ignored.
- div 7/0 -> 0xFFFFFFFF. rem 7/0 -> 7. div 0x80000000/0xFFFFFFFF -> 0x80000000. rem -7/2 -> 0xFFFFFFFF.
- Assert rst_n=0 at cycle 10 of a divu -> no out_valid; next cycle state is IDLE, in_ready=1, result=0.
- ALUop=10, funct7=0000001 with MD_EN=0 -> illegal=1, result=0. ALUop=11, funct3=101, funct7=0100000, op_a=0x80000000, op_b=4 -> result=0xF8000000.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Registered execute stage: decodes {ALUop, funct3, funct7}, runs single-cycle ALU/branch ops
// and iterative RV32M-style multiply/divide behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int unsigned XLEN  = 32,
    parameter bit          MD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUop,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic            illegal
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_BR, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_t;

    state_t state, state_next;
    op_t    op;
    logic   accept, is_mul, is_div, md_done;

    logic [XLEN-1:0] alu_res, diff;
    logic            taken, lt_s, lt_u;
    logic [SHW-1:0]  shamt;

    // a_reg/b_reg/acc hold multiplicand/multiplier/product for MUL and
    // dividend-then-quotient/divisor/partial remainder for DIV.
    logic [XLEN-1:0] a_reg, b_reg, acc, a_orig;
    logic [CW-1:0]   cnt;
    logic            md_rem, neg_res, div_zero;

    logic [XLEN-1:0] mul_sum, div_sub, quo_n, rem_n, md_val, md_final;
    logic [XLEN:0]   div_shift;
    logic            div_ok;

    function automatic op_t base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_comb begin
        op = OP_ILL;
        case (ALUop)
            2'b00: op = OP_ADD;
            2'b01: op = (funct3[2:1] == 2'b01) ? OP_ILL : OP_BR;
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    op = base_op(funct3);
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      op = OP_SUB;
                    else if (funct3 == 3'b101) op = OP_SRA;
                end else if (funct7 == 7'b0000001 && MD_EN) begin
                    case (funct3)
                        3'b000:  op = OP_MUL;
                        3'b100:  op = OP_DIV;
                        3'b101:  op = OP_DIVU;
                        3'b110:  op = OP_REM;
                        3'b111:  op = OP_REMU;
                        default: op = OP_ILL;
                    endcase
                end
            end
            default: begin
                if (funct3 == 3'b001) begin
                    op = (funct7 == 7'b0000000) ? OP_SLL : OP_ILL;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000)      op = OP_SRL;
                    else if (funct7 == 7'b0100000) op = OP_SRA;
                end else begin
                    op = base_op(funct3);
                end
            end
        endcase
    end

    always_comb begin
        shamt   = op_b[SHW-1:0];
        diff    = op_a - op_b;
        lt_s    = $signed(op_a) < $signed(op_b);
        lt_u    = op_a < op_b;
        alu_res = '0;
        taken   = 1'b0;
        case (op)
            OP_ADD:        alu_res = op_a + op_b;
            OP_SUB, OP_BR: alu_res = diff;
            OP_SLL:        alu_res = op_a << shamt;
            OP_SLT:        alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU:       alu_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_XOR:        alu_res = op_a ^ op_b;
            OP_SRL:        alu_res = op_a >> shamt;
            OP_SRA:        alu_res = $signed(op_a) >>> shamt;
            OP_OR:         alu_res = op_a | op_b;
            OP_AND:        alu_res = op_a & op_b;
            default:       alu_res = '0;
        endcase
        if (op == OP_BR) begin
            case (funct3)
                3'b000:  taken = (diff == '0);
                3'b001:  taken = (diff != '0);
                3'b100:  taken = lt_s;
                3'b101:  taken = ~lt_s;
                3'b110:  taken = lt_u;
                3'b111:  taken = ~lt_u;
                default: taken = 1'b0;
            endcase
        end
    end

    assign accept  = in_valid && in_ready;
    assign is_mul  = (op == OP_MUL);
    assign is_div  = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign md_done = (state != IDLE) && (cnt == CNT_LAST);

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = acc + (b_reg[0] ? a_reg : '0);
        div_shift = {acc, a_reg[XLEN-1]};
        div_ok    = div_shift >= {1'b0, b_reg};
        div_sub   = div_shift[XLEN-1:0] - b_reg;
        quo_n     = {a_reg[XLEN-2:0], div_ok};
        rem_n     = div_ok ? div_sub : div_shift[XLEN-1:0];
        md_val    = md_rem ? rem_n : quo_n;
        if (state == MUL)  md_final = mul_sum;
        else if (div_zero) md_final = md_rem ? a_orig : '1;
        else               md_final = neg_res ? -md_val : md_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mul)      state_next = MUL;
                else if (accept && is_div) state_next = DIV;
            end
            default: if (md_done) state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            result       <= '0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            cnt          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            acc          <= '0;
            a_orig       <= '0;
            md_rem       <= 1'b0;
            neg_res      <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                cnt <= '0;
                acc <= '0;
                if (is_mul) begin
                    a_reg <= op_a;
                    b_reg <= op_b;
                end else if (is_div) begin
                    a_reg    <= ((op inside {OP_DIV, OP_REM}) && op_a[XLEN-1]) ? -op_a : op_a;
                    b_reg    <= ((op inside {OP_DIV, OP_REM}) && op_b[XLEN-1]) ? -op_b : op_b;
                    a_orig   <= op_a;
                    md_rem   <= (op == OP_REM) || (op == OP_REMU);
                    div_zero <= (op_b == '0);
                    case (op)
                        OP_DIV:  neg_res <= op_a[XLEN-1] ^ op_b[XLEN-1];
                        OP_REM:  neg_res <= op_a[XLEN-1];
                        default: neg_res <= 1'b0;
                    endcase
                end else begin
                    out_valid    <= 1'b1;
                    result       <= alu_res;
                    branch_taken <= taken;
                    illegal      <= (op == OP_ILL);
                end
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
                if (state == MUL) begin
                    acc   <= mul_sum;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                end else begin
                    acc   <= rem_n;
                    a_reg <= quo_n;
                end
                if (md_done) begin
                    out_valid    <= 1'b1;
                    result       <= md_final;
                    branch_taken <= 1'b0;
                    illegal      <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expected responses,
// monitors pop and compare on every out_valid pulse.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_valid0;
    logic [1:0]  ALUop;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a, op_b;
    logic        in_ready, out_valid, branch_taken, illegal;
    logic [31:0] result;
    logic        in_ready0, out_valid0, branch_taken0, illegal0;
    logic [31:0] result0;

    typedef struct packed {
        logic [31:0] res;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t  sb[$];
    exp_t  sb0[$];
    string nm[$];
    string nm0[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .MD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .result(result), .branch_taken(branch_taken), .illegal(illegal)
    );

    alu_exec_unit #(.XLEN(32), .MD_EN(1'b0)) dut_nomd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .ALUop(ALUop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid0), .result(result0), .branch_taken(branch_taken0), .illegal(illegal0)
    );

    always @(negedge clk) begin
        if (out_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out_valid: got result=%h with nothing expected", result);
            end else begin
                exp_t  e;
                string n;
                e = sb.pop_front();
                n = nm.pop_front();
                if ({result, branch_taken, illegal} !== {e.res, e.br, e.ill}) begin
                    n_bad++;
                    $display("FAIL %s: got result=%h br=%b ill=%b, expected result=%h br=%b ill=%b",
                             n, result, branch_taken, illegal, e.res, e.br, e.ill);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid0) begin
            n_cmp++;
            if (sb0.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out_valid_nomd: got result=%h with nothing expected", result0);
            end else begin
                exp_t  e;
                string n;
                e = sb0.pop_front();
                n = nm0.pop_front();
                if ({result0, branch_taken0, illegal0} !== {e.res, e.br, e.ill}) begin
                    n_bad++;
                    $display("FAIL %s: got result=%h br=%b ill=%b, expected result=%h br=%b ill=%b",
                             n, result0, branch_taken0, illegal0, e.res, e.br, e.ill);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: in_ready=0 after 100 cycles, expected 1");
        end
    endtask

    task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        ALUop  = aop;
        funct3 = f3;
        funct7 = f7;
        op_a   = a;
        op_b   = b;
    endtask

    task automatic issue(input bit alt, input string name, input logic [1:0] aop,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic eb, input logic ei);
        exp_t e;
        e = '{res: er, br: eb, ill: ei};
        drive(aop, f3, f7, a, b);
        if (alt) begin
            sb0.push_back(e);
            nm0.push_back(name);
            in_valid0 = 1'b1;
        end else begin
            sb.push_back(e);
            nm.push_back(name);
            in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        wait_idle();
    endtask

    // Multi-cycle op with latency measurement and ignored in_valid pulses while busy.
    task automatic issue_timed(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] er);
        exp_t e;
        int   lat = -1;
        e = '{res: er, br: 1'b0, ill: 1'b0};
        drive(2'b10, f3, 7'b0000001, a, b);
        sb.push_back(e);
        nm.push_back(name);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n - 1;
            end else begin
                if (n == 3) chk({name, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
                if (n == 5) begin
                    drive(2'b00, 3'b000, 7'b0000000, 32'd1, 32'd1);
                    in_valid = 1'b1;
                end
                if (n == 8) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk({name, "_latency"}, lat, 32'd32);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        drive(2'b00, 3'b000, 7'b0000000, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {30'd0, branch_taken, illegal}, 32'd0);

        issue(0, "add",      2'b10, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       0, 0);
        issue(0, "ld_add",   2'b00, 3'b010, 7'h20, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 0);
        issue(0, "blt",      2'b01, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1, 0);
        issue(0, "bltu",     2'b01, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 0, 0);
        issue(0, "beq",      2'b01, 3'b000, 7'h00, 32'd5,        32'd5,        32'd0,        1, 0);
        issue(0, "bne",      2'b01, 3'b001, 7'h00, 32'd5,        32'd5,        32'd0,        0, 0);
        issue(0, "bge",      2'b01, 3'b101, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 0, 0);
        issue(0, "bgeu",     2'b01, 3'b111, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1, 0);
        issue(0, "br_ill",   2'b01, 3'b010, 7'h00, 32'd9,        32'd3,        32'd0,        0, 1);
        issue(0, "sub",      2'b10, 3'b000, 7'h20, 32'd5,        32'd7,        32'hFFFFFFFE, 0, 0);
        issue(0, "sll",      2'b10, 3'b001, 7'h00, 32'd1,        32'h3F,       32'h80000000, 0, 0);
        issue(0, "slt",      2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 0);
        issue(0, "sltu",     2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 0);
        issue(0, "xor",      2'b10, 3'b100, 7'h00, 32'hF0F0,     32'hFF00,     32'h0FF0,     0, 0);
        issue(0, "srl",      2'b10, 3'b101, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 0, 0);
        issue(0, "sra",      2'b10, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 0, 0);
        issue(0, "or",       2'b10, 3'b110, 7'h00, 32'hF0,       32'h0F,       32'hFF,       0, 0);
        issue(0, "and",      2'b10, 3'b111, 7'h00, 32'hF0,       32'h3C,       32'h30,       0, 0);
        issue(0, "r_ill_f7", 2'b10, 3'b001, 7'h20, 32'd3,        32'd4,        32'd0,        0, 1);
        issue(0, "r_ill_md", 2'b10, 3'b001, 7'h01, 32'd3,        32'd4,        32'd0,        0, 1);
        issue(0, "srai",     2'b11, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 0, 0);
        issue(0, "slli_ill", 2'b11, 3'b001, 7'h20, 32'd3,        32'd2,        32'd0,        0, 1);
        issue(0, "addi",     2'b11, 3'b000, 7'h7F, 32'd3,        32'hFFFFFFFF, 32'd2,        0, 0);
        issue(0, "slli",     2'b11, 3'b001, 7'h00, 32'd3,        32'd2,        32'hC,        0, 0);

        issue_timed("mul_m1x3", 3'b000, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
        issue(0, "mul",      2'b10, 3'b000, 7'h01, 32'h12345678, 32'h10,       32'h23456780, 0, 0);
        issue(0, "mul_m1sq", 2'b10, 3'b000, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        0, 0);
        issue_timed("div_by0", 3'b100, 32'd7, 32'd0, 32'hFFFFFFFF);
        issue(0, "rem_by0",  2'b10, 3'b110, 7'h01, 32'd7,        32'd0,        32'd7,        0, 0);
        issue(0, "div_ovf",  2'b10, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        issue(0, "rem_ovf",  2'b10, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 0);
        issue(0, "rem_neg",  2'b10, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0);
        issue(0, "div_neg",  2'b10, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0);
        issue(0, "div_negb", 2'b10, 3'b100, 7'h01, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0, 0);
        issue(0, "rem_negb", 2'b10, 3'b110, 7'h01, 32'd100,      32'hFFFFFFF9, 32'd2,        0, 0);
        issue(0, "divu_big", 2'b10, 3'b101, 7'h01, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 0, 0);
        issue(0, "divu_by0", 2'b10, 3'b101, 7'h01, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 0, 0);
        issue(0, "divu",     2'b10, 3'b101, 7'h01, 32'd100,      32'd7,        32'hE,        0, 0);
        issue(0, "remu",     2'b10, 3'b111, 7'h01, 32'd100,      32'd7,        32'd2,        0, 0);

        issue(1, "nomd_add", 2'b10, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       0, 0);
        issue(1, "nomd_mul", 2'b10, 3'b000, 7'h01, 32'd5,        32'd7,        32'd0,        0, 1);

        // divu abandoned by reset in its 10th busy cycle: no response is expected
        drive(2'b10, 3'b101, 7'h01, 32'd100, 32'd7);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(negedge clk);

        issue(0, "post_rst_add", 2'b10, 3'b000, 7'h00, 32'd20, 32'd22, 32'd42, 0, 0);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        chk("sb0_drained", sb0.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
